// File: rtl/sync_combiner_auto.sv
// Composite sync generator: synchronises free-running H/V syncs of unknown
// polarity, learns each polarity from the high/low duty of every period,
// and emits a registered composite sync once both polarities have been
// stable for LOCK_COUNT consecutive V periods.
module sync_combiner_auto #(
    parameter int SYNC_STAGES     = 2,
    parameter int HCNT_WIDTH      = 12,
    parameter int VCNT_WIDTH      = 21,
    parameter int LOCK_COUNT      = 4,
    parameter int OUT_ACTIVE_HIGH = 0
) (
    input  logic clk,
    input  logic nReset,
    input  logic hSyncIn,
    input  logic vSyncIn,
    input  logic modeSel,
    output logic cSync,
    output logic hPolarity,
    output logic vPolarity,
    output logic locked
);

    localparam logic [HCNT_WIDTH-1:0] H_MAX    = {HCNT_WIDTH{1'b1}};
    localparam logic [HCNT_WIDTH-1:0] H_ONE    = {{(HCNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [VCNT_WIDTH-1:0] V_MAX    = {VCNT_WIDTH{1'b1}};
    localparam logic [VCNT_WIDTH-1:0] V_ONE    = {{(VCNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]            LOCK_VAL = 8'(LOCK_COUNT);
    localparam logic                  INACTIVE = (OUT_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

    logic [SYNC_STAGES-1:0] hChainR, vChainR;
    logic                   hEdgeR, vEdgeR, hArmedR, vArmedR, hStaleR, vStaleR;
    logic [HCNT_WIDTH-1:0]  hHighR, hLowR, hHighNextS, hLowNextS;
    logic [VCNT_WIDTH-1:0]  vHighR, vLowR, vHighNextS, vLowNextS;
    logic                   hSyncS, vSyncS, hRiseS, vRiseS, hValidS, vValidS;
    logic                   hMeasS, vMeasS, hPolNextS, vPolNextS, hChangeS, vChangeS;
    logic                   hStaleSetS, vStaleSetS, hStaleNextS, vStaleNextS;
    logic [7:0]             lockCntR, lockCntNextS;
    logic                   lockedNextS, hActS, vActS, combS, cSyncNextS;

    assign hSyncS = hChainR[SYNC_STAGES-1];
    assign vSyncS = vChainR[SYNC_STAGES-1];

    // Metastability synchronisers for both asynchronous sync inputs
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            hChainR <= {SYNC_STAGES{1'b0}};
            vChainR <= {SYNC_STAGES{1'b0}};
        end else begin
            hChainR <= {hChainR[SYNC_STAGES-2:0], hSyncIn};
            vChainR <= {vChainR[SYNC_STAGES-2:0], vSyncIn};
        end
    end

    // H channel: duty measurement, polarity decision and stale detection
    always_comb begin
        hRiseS     = hSyncS & ~hEdgeR;
        hHighNextS = hHighR;
        hLowNextS  = hLowR;
        // The first rise after reset only opens a period; saturated counts are meaningless
        hValidS    = hRiseS & hArmedR & (hHighR != H_MAX) & (hLowR != H_MAX);
        if (hHighR < hLowR) begin
            hMeasS = 1'b1;
        end else if (hHighR > hLowR) begin
            hMeasS = 1'b0;
        end else begin
            hMeasS = hPolarity;
        end
        if (hValidS) begin
            hPolNextS = hMeasS;
        end else begin
            hPolNextS = hPolarity;
        end
        if (hRiseS) begin
            hHighNextS = {HCNT_WIDTH{1'b0}};
            hLowNextS  = {HCNT_WIDTH{1'b0}};
        end else if (hSyncS) begin
            if (hHighR != H_MAX) hHighNextS = hHighR + H_ONE;
            else                 hHighNextS = hHighR;
        end else begin
            if (hLowR != H_MAX) hLowNextS = hLowR + H_ONE;
            else                hLowNextS = hLowR;
        end
        hStaleSetS = ~hStaleR & ((hHighNextS == H_MAX) | (hLowNextS == H_MAX));
        if (hValidS) begin
            hStaleNextS = 1'b0;
        end else if (hStaleSetS) begin
            hStaleNextS = 1'b1;
        end else begin
            hStaleNextS = hStaleR;
        end
        hChangeS = hPolNextS ^ hPolarity;
    end

    // V channel: same measurement as H with the wider period counters
    always_comb begin
        vRiseS     = vSyncS & ~vEdgeR;
        vHighNextS = vHighR;
        vLowNextS  = vLowR;
        vValidS    = vRiseS & vArmedR & (vHighR != V_MAX) & (vLowR != V_MAX);
        if (vHighR < vLowR) begin
            vMeasS = 1'b1;
        end else if (vHighR > vLowR) begin
            vMeasS = 1'b0;
        end else begin
            vMeasS = vPolarity;
        end
        if (vValidS) begin
            vPolNextS = vMeasS;
        end else begin
            vPolNextS = vPolarity;
        end
        if (vRiseS) begin
            vHighNextS = {VCNT_WIDTH{1'b0}};
            vLowNextS  = {VCNT_WIDTH{1'b0}};
        end else if (vSyncS) begin
            if (vHighR != V_MAX) vHighNextS = vHighR + V_ONE;
            else                 vHighNextS = vHighR;
        end else begin
            if (vLowR != V_MAX) vLowNextS = vLowR + V_ONE;
            else                vLowNextS = vLowR;
        end
        vStaleSetS = ~vStaleR & ((vHighNextS == V_MAX) | (vLowNextS == V_MAX));
        if (vValidS) begin
            vStaleNextS = 1'b0;
        end else if (vStaleSetS) begin
            vStaleNextS = 1'b1;
        end else begin
            vStaleNextS = vStaleR;
        end
        vChangeS = vPolNextS ^ vPolarity;
    end

    // Lock qualification and composite sync formation
    always_comb begin
        if (hChangeS | vChangeS | hStaleSetS | vStaleSetS) begin
            lockCntNextS = 8'd0;
        end else if (vValidS) begin
            // Post-update H stale state, so a same-cycle H evaluation counts
            if (hStaleNextS) begin
                lockCntNextS = 8'd0;
            end else if (lockCntR >= LOCK_VAL) begin
                lockCntNextS = LOCK_VAL;
            end else begin
                lockCntNextS = lockCntR + 8'd1;
            end
        end else begin
            lockCntNextS = lockCntR;
        end
        lockedNextS = (lockCntNextS == LOCK_VAL);
        // Normalise to active-high: pass through when polarity is high, invert otherwise
        hActS = hSyncS ~^ hPolarity;
        vActS = vSyncS ~^ vPolarity;
        if (modeSel) begin
            combS = hActS | vActS;
        end else begin
            combS = hActS ^ vActS;
        end
        // Gate on the next lock state so a polarity flip blanks cSync on the same edge
        if (lockedNextS) begin
            if (OUT_ACTIVE_HIGH != 0) cSyncNextS = combS;
            else                      cSyncNextS = ~combS;
        end else begin
            cSyncNextS = INACTIVE;
        end
    end

    // H channel state registers
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            hEdgeR    <= 1'b0;
            hArmedR   <= 1'b0;
            hStaleR   <= 1'b0;
            hHighR    <= {HCNT_WIDTH{1'b0}};
            hLowR     <= {HCNT_WIDTH{1'b0}};
            hPolarity <= 1'b0;
        end else begin
            hEdgeR    <= hSyncS;
            hArmedR   <= hArmedR | hRiseS;
            hStaleR   <= hStaleNextS;
            hHighR    <= hHighNextS;
            hLowR     <= hLowNextS;
            hPolarity <= hPolNextS;
        end
    end

    // V channel state registers
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            vEdgeR    <= 1'b0;
            vArmedR   <= 1'b0;
            vStaleR   <= 1'b0;
            vHighR    <= {VCNT_WIDTH{1'b0}};
            vLowR     <= {VCNT_WIDTH{1'b0}};
            vPolarity <= 1'b0;
        end else begin
            vEdgeR    <= vSyncS;
            vArmedR   <= vArmedR | vRiseS;
            vStaleR   <= vStaleNextS;
            vHighR    <= vHighNextS;
            vLowR     <= vLowNextS;
            vPolarity <= vPolNextS;
        end
    end

    // Lock counter and registered outputs
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            lockCntR <= 8'd0;
            locked   <= 1'b0;
            cSync    <= INACTIVE;
        end else begin
            lockCntR <= lockCntNextS;
            locked   <= lockedNextS;
            cSync    <= cSyncNextS;
        end
    end

endmodule

// File: tb/tb_sync_combiner_auto.sv
// Directed bench for sync_combiner_auto: 64-clock lines with a 5-clock pulse,
// 640-clock frames with a 192-clock pulse, LOCK_COUNT=2, active-low cSync.
module tb_sync_combiner_auto;

    logic clk = 1'b0;
    logic nReset = 1'b1;
    logic hSyncIn = 1'b0;
    logic vSyncIn = 1'b0;
    logic modeSel = 1'b0;
    logic cSync, hPolarity, vPolarity, locked;

    int nVec = 0;
    int nErr = 0;
    int hPos = 0;
    int vPos = 0;
    int drvH = 0;
    int drvV = 0;
    logic hInv = 1'b0;
    logic vInv = 1'b0;
    logic hStuck = 1'b0;
    logic hHeld = 1'b0;
    logic [2:0] hActH = 3'b000;
    logic [2:0] vActH = 3'b000;

    sync_combiner_auto #(
        .SYNC_STAGES    (2),
        .HCNT_WIDTH     (8),
        .VCNT_WIDTH     (16),
        .LOCK_COUNT     (2),
        .OUT_ACTIVE_HIGH(0)
    ) dut (
        .clk      (clk),
        .nReset   (nReset),
        .hSyncIn  (hSyncIn),
        .vSyncIn  (vSyncIn),
        .modeSel  (modeSel),
        .cSync    (cSync),
        .hPolarity(hPolarity),
        .vPolarity(vPolarity),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    // Expected locked cSync: active-high pulses driven two iterations ago, combined, inverted
    function automatic logic expCsync();
        logic c;
        if (modeSel) c = hActH[2] | vActH[2];
        else         c = hActH[2] ^ vActH[2];
        return ~c;
    endfunction

    task automatic driveCycle();
        logic hA, vA;
        hA = (hPos < 5);
        vA = (vPos < 192);
        drvH = hPos;
        drvV = vPos;
        if (hStuck) hSyncIn = hHeld;
        else        hSyncIn = hInv ? hA : ~hA;
        vSyncIn = vInv ? vA : ~vA;
        hActH = {hActH[1:0], hA};
        vActH = {vActH[1:0], vA};
        @(posedge clk);
        #1;
        hPos = (hPos + 1) % 64;
        vPos = (vPos + 1) % 640;
    endtask

    task automatic resetDut(input logic inv);
        nReset = 1'b0;
        hInv = inv;
        vInv = inv;
        hStuck = 1'b0;
        modeSel = 1'b0;
        hPos = 0;
        vPos = 0;
        hActH = 3'b000;
        vActH = 3'b000;
        hSyncIn = inv;
        vSyncIn = inv;
        repeat (3) @(posedge clk);
        #1;
        nReset = 1'b1;
    endtask

    task automatic test_reset();
        #1 nReset = 1'b0;
        #2;
        nVec++; if (cSync !== 1'b1) begin nErr++; $display("FAIL reset_csync: got %b want 1", cSync); end
        nVec++; if (locked !== 1'b0) begin nErr++; $display("FAIL reset_locked: got %b want 0", locked); end
        nVec++; if (hPolarity !== 1'b0) begin nErr++; $display("FAIL reset_hpol: got %b want 0", hPolarity); end
        nVec++; if (vPolarity !== 1'b0) begin nErr++; $display("FAIL reset_vpol: got %b want 0", vPolarity); end
    endtask

    task automatic test_lock_normal();
        resetDut(1'b0);
        // Third V rise is driven in iteration 1472; lock appears three edges later
        for (int j = 0; j < 1475; j++) begin
            driveCycle();
            if (j == 1473) begin
                nVec++; if (locked !== 1'b0) begin nErr++; $display("FAIL lock_early: got %b want 0", locked); end
            end
            if (j == 1474) begin
                nVec++; if (locked !== 1'b1) begin nErr++; $display("FAIL lock_edge: got %b want 1", locked); end
                nVec++; if (cSync !== expCsync()) begin nErr++; $display("FAIL lock_edge_csync: got %b want %b", cSync, expCsync()); end
            end
        end
        nVec++; if (hPolarity !== 1'b0) begin nErr++; $display("FAIL norm_hpol: got %b want 0", hPolarity); end
        nVec++; if (vPolarity !== 1'b0) begin nErr++; $display("FAIL norm_vpol: got %b want 0", vPolarity); end
        for (int k = 0; k < 640; k++) begin
            driveCycle();
            nVec++; if (cSync !== expCsync()) begin nErr++; $display("FAIL xor_stream: cycle %0d got %b want %b", k, cSync, expCsync()); end
        end
    endtask

    task automatic test_polarity_flip();
        bit found;
        found = 1'b0;
        while (hPos != 0) driveCycle();
        hInv = 1'b1;
        for (int k = 0; k < 300 && !found; k++) begin
            driveCycle();
            if (locked !== 1'b1) found = 1'b1;
        end
        if (!found) begin
            nVec++; nErr++; $display("FAIL flip_timeout: locked stayed %b want 0", locked);
        end else begin
            nVec++; if (cSync !== 1'b1) begin nErr++; $display("FAIL flip_csync: got %b want 1", cSync); end
            nVec++; if (hPolarity !== 1'b1) begin nErr++; $display("FAIL flip_hpol: got %b want 1", hPolarity); end
            nVec++; if (vPolarity !== 1'b0) begin nErr++; $display("FAIL flip_vpol: got %b want 0", vPolarity); end
        end
        for (int t = 1; t <= 1280; t++) begin
            driveCycle();
            if (t == 640) begin
                nVec++; if (locked !== 1'b0) begin nErr++; $display("FAIL relock_early: got %b want 0", locked); end
            end
            if (t == 1280) begin
                nVec++; if (locked !== 1'b1) begin nErr++; $display("FAIL relock: got %b want 1", locked); end
            end
        end
        for (int k = 0; k < 128; k++) begin
            driveCycle();
            nVec++; if (cSync !== expCsync()) begin nErr++; $display("FAIL flip_stream: cycle %0d got %b want %b", k, cSync, expCsync()); end
        end
    endtask

    task automatic test_inverted();
        resetDut(1'b1);
        repeat (3200) driveCycle();
        nVec++; if (hPolarity !== 1'b1) begin nErr++; $display("FAIL inv_hpol: got %b want 1", hPolarity); end
        nVec++; if (vPolarity !== 1'b1) begin nErr++; $display("FAIL inv_vpol: got %b want 1", vPolarity); end
        nVec++; if (locked !== 1'b1) begin nErr++; $display("FAIL inv_locked: got %b want 1", locked); end
        for (int k = 0; k < 640; k++) begin
            driveCycle();
            nVec++; if (cSync !== expCsync()) begin nErr++; $display("FAIL inv_stream: cycle %0d got %b want %b", k, cSync, expCsync()); end
        end
    endtask

    task automatic test_mid_reset();
        int rises;
        int lockIter;
        bit done;
        rises = 0;
        lockIter = -10;
        done = 1'b0;
        while (vPos != 100) driveCycle();
        driveCycle();
        #2 nReset = 1'b0;
        #1;
        nVec++; if (cSync !== 1'b1) begin nErr++; $display("FAIL mid_rst_csync: got %b want 1", cSync); end
        nVec++; if (locked !== 1'b0) begin nErr++; $display("FAIL mid_rst_locked: got %b want 0", locked); end
        nVec++; if (hPolarity !== 1'b0) begin nErr++; $display("FAIL mid_rst_hpol: got %b want 0", hPolarity); end
        nVec++; if (vPolarity !== 1'b0) begin nErr++; $display("FAIL mid_rst_vpol: got %b want 0", vPolarity); end
        hInv = 1'b0;
        vInv = 1'b0;
        driveCycle();
        driveCycle();
        nReset = 1'b1;
        // Released inside the V pulse: first rise only arms, lock after the third
        for (int k = 0; k < 2500 && !done; k++) begin
            driveCycle();
            if (drvV == 192) begin
                rises++;
                if (rises == 3) lockIter = k;
            end
            if (k == lockIter + 1) begin
                nVec++; if (locked !== 1'b0) begin nErr++; $display("FAIL mid_relock_early: got %b want 0", locked); end
            end
            if (k == lockIter + 2) begin
                nVec++; if (locked !== 1'b1) begin nErr++; $display("FAIL mid_relock: got %b want 1", locked); end
                done = 1'b1;
            end
        end
        if (!done) begin
            nVec++; nErr++; $display("FAIL mid_relock_timeout: rises=%0d want 3", rises);
        end
    endtask

    task automatic test_mode_switch();
        while (vPos != 0) driveCycle();
        modeSel = 1'b1;
        for (int k = 0; k < 640; k++) begin
            driveCycle();
            nVec++; if (cSync !== expCsync()) begin nErr++; $display("FAIL or_stream: cycle %0d got %b want %b", k, cSync, expCsync()); end
            nVec++; if (locked !== 1'b1) begin nErr++; $display("FAIL or_locked: cycle %0d got %b want 1", k, locked); end
        end
        modeSel = 1'b0;
    endtask

    task automatic test_stale();
        while (hPos != 10) driveCycle();
        nVec++; if (locked !== 1'b1) begin nErr++; $display("FAIL stale_pre: got %b want 1", locked); end
        hHeld = hSyncIn;
        hStuck = 1'b1;
        // Counter cleared at the pos-5 rise reaches all-ones 252 iterations into the hold
        for (int k = 0; k < 300; k++) begin
            driveCycle();
            if (k == 251) begin
                nVec++; if (locked !== 1'b1) begin nErr++; $display("FAIL stale_before_sat: got %b want 1", locked); end
            end
            if (k == 252) begin
                nVec++; if (locked !== 1'b0) begin nErr++; $display("FAIL stale_at_sat: got %b want 0", locked); end
                nVec++; if (cSync !== 1'b1) begin nErr++; $display("FAIL stale_csync_sat: got %b want 1", cSync); end
            end
        end
        nVec++; if (locked !== 1'b0) begin nErr++; $display("FAIL stale_end_locked: got %b want 0", locked); end
        nVec++; if (cSync !== 1'b1) begin nErr++; $display("FAIL stale_end_csync: got %b want 1", cSync); end
        hStuck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_normal();
        test_polarity_flip();
        test_inverted();
        test_mid_reset();
        test_mode_switch();
        test_stale();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
